// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller side, slave = datapath / fetch side.
interface mips_multicycle_ctrl_if;
    logic        inst_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        alu_zero;
    logic        mem_ready;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        reg_dst;
    logic        mem_to_reg;
    logic        alu_src_b;
    logic [3:0]  alu_ctrl;
    logic        ext_sign;
    logic        illegal;
    logic        busy;
    logic [31:0] retired_cnt;

    modport master (
        input  inst_valid, opcode, funct, alu_zero, mem_ready,
        output ir_write, pc_write, pc_src, mem_read, mem_write,
        output reg_write, reg_dst, mem_to_reg, alu_src_b, alu_ctrl,
        output ext_sign, illegal, busy, retired_cnt
    );

    modport slave (
        output inst_valid, opcode, funct, alu_zero, mem_ready,
        input  ir_write, pc_write, pc_src, mem_read, mem_write,
        input  reg_write, reg_dst, mem_to_reg, alu_src_b, alu_ctrl,
        input  ext_sign, illegal, busy, retired_cnt
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Define MIPS_CTRL_RETIRE_CNT_EN to build the retired-instruction counter.
module mips_multicycle_ctrl (
    input logic                   clk,
    input logic                   rst_n,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_e     state_q, state_d;
    logic [5:0] op_q, op_d;
    logic [5:0] fn_q, fn_d;

    logic       legal;
    logic       is_r;
    logic       is_imm;
    logic       is_lw;
    logic       is_sw;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
    logic [3:0] alu_op;
    logic       zext_q;
    logic       zext_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            fn_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            fn_q    <= fn_d;
        end
    end

    always_comb begin
        legal  = 1'b0;
        is_r   = 1'b0;
        is_imm = 1'b0;
        is_lw  = 1'b0;
        is_sw  = 1'b0;
        is_beq = 1'b0;
        is_bne = 1'b0;
        is_j   = 1'b0;
        alu_op = ALU_AND;
        case (op_q)
            6'h00: begin
                is_r = 1'b1;
                case (fn_q)
                    6'h20: begin legal = 1'b1; alu_op = ALU_ADD; end
                    6'h22: begin legal = 1'b1; alu_op = ALU_SUB; end
                    6'h24: begin legal = 1'b1; alu_op = ALU_AND; end
                    6'h25: begin legal = 1'b1; alu_op = ALU_OR;  end
                    6'h2A: begin legal = 1'b1; alu_op = ALU_SLT; end
                    default: legal = 1'b0;
                endcase
            end
            6'h08: begin legal = 1'b1; is_imm = 1'b1; alu_op = ALU_ADD; end
            6'h0A: begin legal = 1'b1; is_imm = 1'b1; alu_op = ALU_SLT; end
            6'h0C: begin legal = 1'b1; is_imm = 1'b1; alu_op = ALU_AND; end
            6'h0D: begin legal = 1'b1; is_imm = 1'b1; alu_op = ALU_OR;  end
            6'h23: begin legal = 1'b1; is_lw  = 1'b1; alu_op = ALU_ADD; end
            6'h2B: begin legal = 1'b1; is_sw  = 1'b1; alu_op = ALU_ADD; end
            6'h04: begin legal = 1'b1; is_beq = 1'b1; alu_op = ALU_SUB; end
            6'h05: begin legal = 1'b1; is_bne = 1'b1; alu_op = ALU_SUB; end
            6'h02: begin legal = 1'b1; is_j   = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

    // andi/ori zero-extend; everything else sign-extends
    assign zext_q  = (op_q == 6'h0C) || (op_q == 6'h0D);
    assign zext_in = (bus.opcode == 6'h0C) || (bus.opcode == 6'h0D);

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        fn_d           = fn_q;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'b00;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_b  = 1'b0;
        bus.alu_ctrl   = 4'b0000;
        bus.ext_sign   = 1'b0;
        bus.illegal    = 1'b0;
        bus.busy       = 1'b1;
        unique case (state_q)
            S_FETCH: begin
                bus.busy = 1'b0;
                if (bus.inst_valid) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    bus.ext_sign = !zext_in;
                    op_d         = bus.opcode;
                    fn_d         = bus.funct;
                    state_d      = S_DECODE;
                end
            end
            S_DECODE: begin
                bus.ext_sign = !zext_q;
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    bus.illegal = 1'b1;
                    state_d     = S_FETCH;
                end
            end
            S_EXEC: begin
                bus.ext_sign  = !zext_q;
                bus.alu_src_b = is_imm || is_lw || is_sw;
                bus.alu_ctrl  = alu_op;
                if (is_beq || is_bne) begin
                    bus.pc_src   = 2'b01;
                    bus.pc_write = is_beq ? bus.alu_zero : !bus.alu_zero;
                    state_d      = S_FETCH;
                end else if (is_j) begin
                    bus.pc_src   = 2'b10;
                    bus.pc_write = 1'b1;
                    state_d      = S_FETCH;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                bus.ext_sign  = !zext_q;
                bus.mem_read  = is_lw;
                bus.mem_write = is_sw;
                if (bus.mem_ready) begin
                    state_d = is_lw ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                bus.ext_sign   = !zext_q;
                bus.reg_write  = 1'b1;
                bus.reg_dst    = is_r;
                bus.mem_to_reg = is_lw;
                state_d        = S_FETCH;
            end
            default: begin
                bus.busy = 1'b0;
                state_d  = S_FETCH;
            end
        endcase
    end

`ifdef MIPS_CTRL_RETIRE_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        retire;

    // a return to FETCH from DECODE is an illegal op, not a retirement
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_EXEC) || (state_q == S_MEM) ||
                     (state_q == S_WB));
    assign cnt_d  = cnt_q + 32'(retire);

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign bus.retired_cnt = cnt_q;
`else
    assign bus.retired_cnt = '0;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized bench for mips_multicycle_ctrl against a per-instruction
// trace model built from the instruction table.
module tb_mips_multicycle_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_b;
        logic [3:0] alu_ctrl;
        logic       ext_sign;
        logic       illegal;
        logic       busy;
    } ctl_t;

    // cls: 0 R-type, 1 immediate, 2 lw, 3 sw, 4 beq, 5 bne, 6 j
    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic [3:0] alu;
        logic [2:0] cls;
    } ins_t;

    ins_t tbl [14];
    int   n_chk = 0;
    int   n_err = 0;
    logic [31:0] cnt_exp = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic retire();
`ifdef MIPS_CTRL_RETIRE_CNT_EN
        cnt_exp = cnt_exp + 32'd1;
`endif
    endtask

    // one cycle: drive inputs at negedge, sample #1 later
    task automatic step(input string tag, input ctl_t e, input logic iv,
                        input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rdy);
        ctl_t o;
        @(negedge clk);
        bus.inst_valid = iv;
        bus.opcode     = op;
        bus.funct      = fn;
        bus.alu_zero   = z;
        bus.mem_ready  = rdy;
        #1;
        o = '{bus.ir_write, bus.pc_write, bus.pc_src, bus.mem_read,
              bus.mem_write, bus.reg_write, bus.reg_dst, bus.mem_to_reg,
              bus.alu_src_b, bus.alu_ctrl, bus.ext_sign, bus.illegal,
              bus.busy};
        check({tag, " ctl"}, 32'(o), 32'(e));
        check({tag, " cnt"}, bus.retired_cnt, cnt_exp);
    endtask

    function automatic logic [5:0] r6();
        return 6'($urandom);
    endfunction

    function automatic logic r1();
        return 1'($urandom);
    endfunction

    task automatic idle();
        step("idle", '0, 1'b0, r6(), r6(), r1(), r1());
    endtask

    task automatic run_inst(input logic [5:0] op, input logic [5:0] fn,
                            input int waits, input logic z,
                            input bit abort);
        ctl_t e;
        ins_t t;
        bit   legal = 0;
        logic es;
        t = '0;
        foreach (tbl[i])
            if (tbl[i].op == op && (op != 6'h00 || tbl[i].fn == fn)) begin
                legal = 1;
                t = tbl[i];
            end
        es = !(op == 6'h0C || op == 6'h0D);

        e = '0; e.ir_write = 1; e.pc_write = 1; e.ext_sign = es;
        step("fetch", e, 1'b1, op, fn, r1(), r1());

        e = '0; e.busy = 1; e.ext_sign = es; e.illegal = !legal;
        step("decode", e, r1(), r6(), r6(), r1(), r1());
        if (!legal) return;

        e = '0; e.busy = 1; e.ext_sign = es; e.alu_ctrl = t.alu;
        e.alu_src_b = (t.cls == 1 || t.cls == 2 || t.cls == 3);
        if (t.cls == 4) begin e.pc_src = 2'b01; e.pc_write = z;  end
        if (t.cls == 5) begin e.pc_src = 2'b01; e.pc_write = !z; end
        if (t.cls == 6) begin e.pc_src = 2'b10; e.pc_write = 1;  end
        step("exec", e, r1(), r6(), r6(), z, r1());
        if (t.cls >= 4) begin retire(); return; end

        if (t.cls == 2 || t.cls == 3) begin
            for (int i = 0; i <= waits; i++) begin
                e = '0; e.busy = 1; e.ext_sign = es;
                e.mem_read = (t.cls == 2); e.mem_write = (t.cls == 3);
                step("mem", e, r1(), r6(), r6(), r1(),
                     (i == waits) && !abort);
                if (abort && i == 1) begin
                    rst_n = 1'b0;
                    cnt_exp = '0;
                    step("rst", '0, 1'b0, r6(), r6(), r1(), r1());
                    rst_n = 1'b1;
                    return;
                end
            end
            if (t.cls == 3) begin retire(); return; end
        end

        e = '0; e.busy = 1; e.ext_sign = es; e.reg_write = 1;
        e.reg_dst = (t.cls == 0); e.mem_to_reg = (t.cls == 2);
        step("wb", e, r1(), r6(), r6(), r1(), r1());
        retire();
    endtask

    initial begin
        int k;
        tbl = '{
            '{6'h00, 6'h20, 4'b0010, 3'd0}, '{6'h00, 6'h22, 4'b0110, 3'd0},
            '{6'h00, 6'h24, 4'b0000, 3'd0}, '{6'h00, 6'h25, 4'b0001, 3'd0},
            '{6'h00, 6'h2A, 4'b0111, 3'd0}, '{6'h08, 6'h00, 4'b0010, 3'd1},
            '{6'h0A, 6'h00, 4'b0111, 3'd1}, '{6'h0C, 6'h00, 4'b0000, 3'd1},
            '{6'h0D, 6'h00, 4'b0001, 3'd1}, '{6'h23, 6'h00, 4'b0010, 3'd2},
            '{6'h2B, 6'h00, 4'b0010, 3'd3}, '{6'h04, 6'h00, 4'b0110, 3'd4},
            '{6'h05, 6'h00, 4'b0110, 3'd5}, '{6'h02, 6'h00, 4'b0000, 3'd6}
        };
        bus.inst_valid = 1'b0;
        bus.opcode     = '0;
        bus.funct      = '0;
        bus.alu_zero   = 1'b0;
        bus.mem_ready  = 1'b0;
        repeat (2) @(posedge clk);
        step("reset", '0, 1'b0, r6(), r6(), r1(), r1());
        rst_n = 1'b1;
        idle();

        run_inst(6'h00, 6'h20, 0, 1'b0, 0);
        run_inst(6'h0C, r6(), 0, 1'b0, 0);
        run_inst(6'h08, r6(), 0, 1'b0, 0);
        run_inst(6'h23, r6(), 3, 1'b0, 0);
        run_inst(6'h04, r6(), 0, 1'b1, 0);
        run_inst(6'h04, r6(), 0, 1'b0, 0);
        run_inst(6'h02, r6(), 0, 1'b0, 0);
        run_inst(6'h3F, r6(), 0, 1'b0, 0);
        idle();
        run_inst(6'h2B, r6(), 3, 1'b0, 1);
        idle();

        for (int n = 0; n < 400; n++) begin
            repeat ($urandom_range(0, 2)) idle();
            k = $urandom_range(0, 16);
            if (k < 14)
                run_inst(tbl[k].op, tbl[k].op == 6'h00 ? tbl[k].fn : r6(),
                         $urandom_range(0, 3), r1(), 0);
            else if (k == 14)
                run_inst(6'h00, 6'h21, 0, r1(), 0);
            else if (k == 15)
                run_inst(6'h3F, r6(), 0, r1(), 0);
            else
                run_inst(6'h2B, r6(), 2, r1(), 1);
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
